// File: rtl/rvm_muldiv.sv
// rvm_muldiv: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide retire STEP bits per CALC cycle
// on unsigned magnitudes. Signs are folded back in when the result is written.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// PREP  | take magnitudes, record result sign, detect divide special cases
// CALC  | XLEN/STEP iterations of shift-add or restoring divide
// DONE  | result visible, valid pulses for this one cycle
module rvm_muldiv #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] lhs,
   input  logic [XLEN-1:0] rhs,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);

   localparam int NCYC = XLEN / STEP;
   localparam int CW   = $clog2(NCYC) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   state_t state, state_nxt;

   logic [2:0]      op_q;
   logic [XLEN-1:0] lhs_q, rhs_q;
   logic [XLEN-1:0] opb_q;
   logic [XLEN-1:0] acc_hi, acc_lo;
   logic            neg_q;
   logic [CW-1:0]   cnt;

   logic            is_div, is_rem, lhs_signed, rhs_signed;
   logic            a_neg, b_neg, div_zero, div_ovf, special;
   logic [XLEN-1:0] abs_a, abs_b, special_res;
   logic [XLEN-1:0] hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] q_fix, r_fix, calc_res;

   assign busy = (state != IDLE);

   // Operand decode: signedness, magnitudes and divide special cases
   always_comb begin
      is_div      = op_q[2];
      is_rem      = op_q[2] & op_q[1];
      lhs_signed  = (op_q == 3'd1) | (op_q == 3'd2) | (op_q == 3'd4) | (op_q == 3'd6);
      rhs_signed  = (op_q == 3'd1) | (op_q == 3'd4) | (op_q == 3'd6);
      a_neg       = lhs_signed & lhs_q[XLEN-1];
      b_neg       = rhs_signed & rhs_q[XLEN-1];
      abs_a       = a_neg ? -lhs_q : lhs_q;
      abs_b       = b_neg ? -rhs_q : rhs_q;
      div_zero    = is_div & (rhs_q == '0);
      div_ovf     = is_div & ~op_q[0] & (lhs_q == {1'b1, {(XLEN-1){1'b0}}}) & (rhs_q == '1);
      special     = div_zero | div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = is_rem ? lhs_q : '1;
      else
         special_res = is_rem ? '0 : lhs_q;
   end

   // One CALC cycle worth of iterations: acc_hi is the running high product or
   // partial remainder, acc_lo holds the multiplier or dividend/quotient bits
   always_comb begin
      logic [XLEN-1:0] h, l;
      logic [XLEN:0]   s;
      h = acc_hi;
      l = acc_lo;
      s = '0;
      for (int i = 0; i < STEP; i++) begin
         if (!is_div) begin
            s = {1'b0, h} + (l[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
            h = s[XLEN:1];
            l = {s[0], l[XLEN-1:1]};
         end else begin
            s = {h, l[XLEN-1]};
            l = {l[XLEN-2:0], 1'b0};
            if (s >= {1'b0, opb_q}) begin
               s    = s - {1'b0, opb_q};
               l[0] = 1'b1;
            end
            h = s[XLEN-1:0];
         end
      end
      hi_nxt = h;
      lo_nxt = l;
   end

   // Sign correction and result selection from the final iteration's values
   always_comb begin
      prod     = {hi_nxt, lo_nxt};
      prod_fix = neg_q ? -prod : prod;
      q_fix    = neg_q ? -lo_nxt : lo_nxt;
      r_fix    = neg_q ? -hi_nxt : hi_nxt;
      if (is_div)
         calc_res = is_rem ? r_fix : q_fix;
      else if (op_q == 3'd0)
         calc_res = prod_fix[XLEN-1:0];
      else
         calc_res = prod_fix[2*XLEN-1:XLEN];
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = special ? DONE : CALC;
         CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush)
         state_nxt = IDLE;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Operand capture, PREP setup and iteration datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= '0;
         lhs_q  <= '0;
         rhs_q  <= '0;
         opb_q  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_q  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  op_q  <= op;
                  lhs_q <= lhs;
                  rhs_q <= rhs;
               end
            end
            PREP: begin
               neg_q  <= is_rem ? a_neg : (a_neg ^ b_neg);
               opb_q  <= is_div ? abs_b : abs_a;
               acc_lo <= is_div ? abs_a : abs_b;
               acc_hi <= '0;
               cnt    <= '0;
            end
            CALC: begin
               acc_hi <= hi_nxt;
               acc_lo <= lo_nxt;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result is loaded on the edge into DONE so it is visible with valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= '0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!flush) begin
            if (state == PREP && special) begin
               result <= special_res;
               valid  <= 1'b1;
            end else if (state == CALC && cnt == CNT_LAST) begin
               result <= calc_res;
               valid  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rvm_muldiv.sv
// tb_rvm_muldiv: randomized and directed checks of two rvm_muldiv instances
// (XLEN=32/STEP=1 and XLEN=64/STEP=4) against an arithmetic reference model.
module tb_rvm_muldiv;

   logic        clk;
   logic        rst0, start0, flush0;
   logic [2:0]  op0;
   logic [31:0] lhs0, rhs0, result0;
   logic        busy0, valid0;
   logic        rst1, start1, flush1;
   logic [2:0]  op1;
   logic [63:0] lhs1, rhs1, result1;
   logic        busy1, valid1;

   rvm_muldiv #(.XLEN(32), .STEP(1)) dut0 (
      .clk(clk), .reset(rst0), .start(start0), .op(op0), .lhs(lhs0), .rhs(rhs0),
      .flush(flush0), .busy(busy0), .valid(valid0), .result(result0));

   rvm_muldiv #(.XLEN(64), .STEP(4)) dut1 (
      .clk(clk), .reset(rst1), .start(start1), .op(op1), .lhs(lhs1), .rhs(rhs1),
      .flush(flush1), .busy(busy1), .valid(valid1), .result(result1));

   int          chk_total = 0;
   int          chk_pass  = 0;
   int          cyc       = 0;
   logic        pend      [2];
   int          pend_start[2];
   int          pend_due  [2];
   logic [63:0] pend_res  [2];
   logic [63:0] held      [2];
   int          vcyc      [2];
   int          issued_at [2];

   logic        m_busy, m_valid, m_bexp;
   logic [63:0] m_res;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_total++;
      if (act === exp)
         chk_pass++;
      else
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   function automatic logic [63:0] xmask(input int xl);
      return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic longint sval(input int xl, input logic [63:0] v);
      return (xl == 32) ? longint'($signed(v[31:0])) : longint'(v);
   endfunction

   function automatic logic is_special(input int xl, input logic [2:0] o,
                                       input logic [63:0] a, input logic [63:0] b);
      longint mn;
      mn = (xl == 32) ? -(longint'(1) << 31) : longint'(64'h8000_0000_0000_0000);
      if (!o[2]) return 1'b0;
      if ((b & xmask(xl)) == 64'd0) return 1'b1;
      return !o[0] && sval(xl, a) == mn && sval(xl, b) == -64'sd1;
   endfunction

   // Reference: RISC-V M semantics with wide signed/unsigned arithmetic
   function automatic logic [63:0] ref_op(input int xl, input logic [2:0] o,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [63:0]         ua, ub, r;
      longint              sa, sb;
      logic signed [129:0] xas, xbs, xau, xbu, p;
      ua  = a & xmask(xl);
      ub  = b & xmask(xl);
      sa  = sval(xl, a);
      sb  = sval(xl, b);
      xas = sa;
      xbs = sb;
      xau = {66'd0, ua};
      xbu = {66'd0, ub};
      p   = '0;
      r   = '0;
      case (o)
         3'd0: begin p = xau * xbu; r = p[63:0]; end
         3'd1: begin p = xas * xbs; r = (xl == 32) ? {32'd0, p[63:32]} : p[127:64]; end
         3'd2: begin p = xas * xbu; r = (xl == 32) ? {32'd0, p[63:32]} : p[127:64]; end
         3'd3: begin p = xau * xbu; r = (xl == 32) ? {32'd0, p[63:32]} : p[127:64]; end
         3'd4: if (ub == 0) r = '1; else if (is_special(xl, o, a, b)) r = ua; else r = sa / sb;
         3'd5: if (ub == 0) r = '1; else r = ua / ub;
         3'd6: if (ub == 0) r = ua; else if (is_special(xl, o, a, b)) r = '0; else r = sa % sb;
         default: if (ub == 0) r = ua; else r = ua % ub;
      endcase
      return r & xmask(xl);
   endfunction

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return '1;
         2: return 64'h8000_0000_8000_0000;
         3: return 64'($urandom_range(0, 20));
         4: return -64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Compare process: checks busy, valid and result of both DUTs every cycle
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         m_busy  = (d == 0) ? busy0 : busy1;
         m_valid = (d == 0) ? valid0 : valid1;
         m_res   = (d == 0) ? {32'd0, result0} : result1;
         m_bexp  = pend[d] && (cyc > pend_start[d]);
         check($sformatf("d%0d_busy", d), {63'd0, m_busy}, {63'd0, m_bexp});
         if (pend[d] && cyc == pend_due[d]) begin
            check($sformatf("d%0d_valid_due", d), {63'd0, m_valid}, 64'd1);
            check($sformatf("d%0d_result", d), m_res, pend_res[d]);
            held[d] = pend_res[d];
            pend[d] = 1'b0;
         end else begin
            check($sformatf("d%0d_valid_quiet", d), {63'd0, m_valid}, 64'd0);
            check($sformatf("d%0d_result_hold", d), m_res, held[d]);
         end
         if (m_valid) vcyc[d] = cyc;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic s, input logic [2:0] o,
                        input logic [63:0] a, input logic [63:0] b);
      if (d == 0) begin
         start0 = s; op0 = o; lhs0 = a[31:0]; rhs0 = b[31:0];
      end else begin
         start1 = s; op1 = o; lhs1 = a; rhs1 = b;
      end
   endtask

   task automatic issue(input int d, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      int xl;
      xl = (d == 0) ? 32 : 64;
      drive(d, 1'b1, o, a, b);
      pend[d]       = 1'b1;
      pend_start[d] = cyc;
      issued_at[d]  = cyc;
      pend_res[d]   = ref_op(xl, o, a, b);
      pend_due[d]   = cyc + (is_special(xl, o, a, b) ? 2 : ((d == 0) ? 34 : 18));
      step();
      if (d == 0) start0 = 1'b0; else start1 = 1'b0;
   endtask

   task automatic poke(input int d, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      drive(d, 1'b1, o, a, b);
      step();
      if (d == 0) start0 = 1'b0; else start1 = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n;
      n = 0;
      while (pend[d] && n < 300) begin
         step();
         n++;
      end
      check($sformatf("d%0d_timeout", d), {63'd0, pend[d]}, 64'd0);
      pend[d] = 1'b0;
      step();
   endtask

   task automatic random_ops(input int d, input int count);
      logic [2:0]  o;
      logic [63:0] a, b;
      for (int i = 0; i < count; i++) begin
         o = 3'($urandom_range(0, 7));
         a = rnd_val();
         b = rnd_val();
         issue(d, o, a, b);
         if ($urandom_range(0, 3) == 0) poke(d, 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
         wait_done(d);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         pend[d] = 1'b0; pend_start[d] = 0; pend_due[d] = 0;
         pend_res[d] = '0; held[d] = '0; vcyc[d] = 0; issued_at[d] = 0;
      end
      rst0 = 1'b1; rst1 = 1'b1;
      start0 = 1'b0; flush0 = 1'b0; op0 = '0; lhs0 = '0; rhs0 = '0;
      start1 = 1'b0; flush1 = 1'b0; op1 = '0; lhs1 = '0; rhs1 = '0;
      #1;
      check("rst_busy0", {63'd0, busy0}, 64'd0);
      check("rst_valid0", {63'd0, valid0}, 64'd0);
      check("rst_result0", {32'd0, result0}, 64'd0);
      check("rst_result1", result1, 64'd0);
      step();
      step();
      rst0 = 1'b0; rst1 = 1'b0;
      step();

      // Hand-computed expectations for the 32-bit, 1-bit-per-cycle unit
      issue(0, 3'd0, 64'd7, -64'd3);
      wait_done(0);
      check("mul_7x-3", {32'd0, result0}, 64'h0000_0000_FFFF_FFEB);
      check("mul_latency", 64'(vcyc[0] - issued_at[0]), 64'd34);
      issue(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_done(0);
      check("mulhu_ones", {32'd0, result0}, 64'h0000_0000_FFFF_FFFE);
      issue(0, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_done(0);
      check("mulh_ones", {32'd0, result0}, 64'd0);
      issue(0, 3'd4, -64'd7, 64'd2);
      wait_done(0);
      check("div_-7_2", {32'd0, result0}, 64'h0000_0000_FFFF_FFFD);
      check("div_latency", 64'(vcyc[0] - issued_at[0]), 64'd34);
      issue(0, 3'd6, -64'd7, 64'd2);
      wait_done(0);
      check("rem_-7_2", {32'd0, result0}, 64'h0000_0000_FFFF_FFFF);
      issue(0, 3'd5, 64'd1234, 64'd0);
      wait_done(0);
      check("divu_by_zero", {32'd0, result0}, 64'h0000_0000_FFFF_FFFF);
      check("divz_latency", 64'(vcyc[0] - issued_at[0]), 64'd2);
      issue(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF);
      wait_done(0);
      check("div_overflow", {32'd0, result0}, 64'h0000_0000_8000_0000);
      check("ovf_latency", 64'(vcyc[0] - issued_at[0]), 64'd2);

      // Flush in the middle of CALC: no valid, result keeps its old value
      issue(0, 3'd0, 64'd123, 64'd456);
      repeat (10) step();
      flush0 = 1'b1;
      pend[0] = 1'b0;
      step();
      flush0 = 1'b0;
      check("flush_busy", {63'd0, busy0}, 64'd0);
      repeat (40) step();

      // Start while busy is ignored
      issue(0, 3'd5, 64'd1000, 64'd9);
      repeat (3) step();
      poke(0, 3'd0, 64'd2, 64'd3);
      wait_done(0);
      check("busy_start_ignored", {32'd0, result0}, 64'd111);

      // Flush wins over a simultaneous start
      flush0 = 1'b1;
      drive(0, 1'b1, 3'd0, 64'd5, 64'd5);
      step();
      flush0 = 1'b0;
      start0 = 1'b0;
      check("flush_start_busy", {63'd0, busy0}, 64'd0);
      repeat (5) step();

      random_ops(0, 60);

      // 64-bit, 4-bits-per-cycle unit
      issue(1, 3'd5, 64'd100, 64'd7);
      wait_done(1);
      check("divu_100_7", result1, 64'd14);
      check("divu64_latency", 64'(vcyc[1] - issued_at[1]), 64'd18);
      issue(1, 3'd7, 64'd100, 64'd7);
      wait_done(1);
      check("remu_100_7", result1, 64'd2);

      // Reset mid-CALC clears outputs immediately and drops the operation
      issue(1, 3'd5, 64'd100000, 64'd3);
      repeat (5) step();
      rst1 = 1'b1;
      pend[1] = 1'b0;
      held[1] = '0;
      #1;
      check("midrst_busy", {63'd0, busy1}, 64'd0);
      check("midrst_valid", {63'd0, valid1}, 64'd0);
      check("midrst_result", result1, 64'd0);
      step();
      rst1 = 1'b0;
      repeat (25) step();

      random_ops(1, 60);

      repeat (3) step();
      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule

// File: doc/rvm_muldiv.md
RVM_MULDIV -- requirements
Module: rvm_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 32 and 64.
REQ-002 SHALL have parameter STEP, default 1, giving the quotient or multiplier bits retired per CALC cycle; legal values are 1, 2 and 4, and XLEN % STEP == 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a new operation (sampled only in IDLE).
REQ-006 SHALL have port op, input, 3 bits: operation select; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port lhs, input, XLEN bits: rs1 operand (multiplicand or dividend).
REQ-008 SHALL have port rhs, input, XLEN bits: rs2 operand (multiplier or divisor).
REQ-009 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse, result is complete.
REQ-012 SHALL have port result, output, XLEN bits: registered result.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC and DONE.
REQ-014 IDLE with start=1 SHALL capture op, lhs and rhs into internal registers; next state PREP. IDLE with start=0 SHALL stay in IDLE.
REQ-015 PREP SHALL take absolute values of the signed operands as selected by op (MULH: both; MULHSU: lhs only; DIV/REM: both), record the result sign, and clear the accumulator and the iteration counter; next state CALC.
REQ-016 PREP special cases SHALL skip CALC and go directly to DONE:
- divisor == 0: DIV/DIVU give all-ones; REM/REMU give lhs.
- signed overflow (lhs == most-negative and rhs == -1, DIV/REM only): DIV gives lhs; REM gives 0.
REQ-017 CALC multiply SHALL use shift-add, STEP multiplier bits per cycle, into a 2*XLEN-bit product.
REQ-018 CALC divide SHALL use restoring division, STEP quotient bits per cycle.
REQ-019 CALC SHALL last exactly XLEN/STEP cycles, counted by a counter of width clog2(XLEN/STEP)+1; next state DONE.
REQ-020 DONE SHALL apply sign correction, write result, and assert valid for exactly one cycle; next state IDLE.
REQ-021 Result selection SHALL be: MUL the low XLEN bits of the product; MULH, MULHSU and MULHU the high XLEN bits; DIV/DIVU the quotient; REM/REMU the remainder.
REQ-022 Result signs SHALL follow the RISC-V M extension: the remainder takes the sign of the dividend; the quotient is negative when the operand signs differ.
REQ-023 Latency, with the start cycle counted as cycle 0, SHALL be: valid high in cycle XLEN/STEP+2 for a normal operation, and in cycle 2 for a special case.
REQ-024 start while busy=1 SHALL be ignored; no capture occurs and the in-flight operation is unaffected.
REQ-025 result SHALL hold its value between valid pulses and change only in DONE.
REQ-026 flush=1 in any state SHALL force IDLE on the next edge with no valid pulse; result is unchanged.
REQ-027 flush takes priority over start in the same cycle; the start is dropped.
REQ-028 start on the cycle immediately after DONE (back-to-back) SHALL be accepted.
REQ-029 op values and operand widths SHALL need no external sign extension; all arithmetic is internal at XLEN+1 or 2*XLEN bits.

Reset
REQ-030 reset=1 SHALL asynchronously force state IDLE, busy=0, valid=0, result=0, counter=0, and clear all operand and accumulator registers.
REQ-031 reset asserted mid-operation SHALL discard the operation; after reset deasserts, no valid pulse occurs until a new start.

Verification
REQ-032 XLEN=32, STEP=1, MUL with lhs=7, rhs=-3 -> valid in cycle 34, result 0xFFFFFFEB.
REQ-033 MULHU with lhs=rhs=0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> result 0x00000000.
REQ-034 DIV with lhs=-7, rhs=2 -> result 0xFFFFFFFD. REM with the same operands -> result 0xFFFFFFFF. Both valid in cycle 34.
REQ-035 DIVU with rhs=0 -> result 0xFFFFFFFF in cycle 2. DIV with lhs=0x80000000, rhs=-1 -> result 0x80000000 in cycle 2.
REQ-036 Issue start, then pulse flush in CALC cycle 10 -> busy=0 on the next cycle and no valid pulse. A start while busy -> ignored.
REQ-037 STEP=4, XLEN=64, DIVU with lhs=100, rhs=7 -> valid in cycle 18, result 14. REMU -> result 2. Assert reset mid-CALC -> all outputs 0 immediately.
